rv32imf_irq_source: RTL and testbench



---
 rtl/rv32imf_irq_source.sv | 179 +++++++++++++++++
 tb/tb_rv32imf_irq_source.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32imf_irq_source.sv
// rv32imf_irq_source
// Interrupt source unit feeding the core's irq vector: software interrupt
// (bit 3), 64-bit mtime/mtimecmp timer interrupt (bit 7), external interrupt
// (bit 11) and 16 rising-edge latched fast interrupts (bits 16..31).
//
// Optional build macro: IRQ_SRC_SYNC_EN
//   defined     : fast_irq_i/ext_irq_i pass a 2-flop synchronizer
//                 (input edge to irq_o latency 3 cycles)
//   not defined : single sample register (latency 1 cycle)
//
// Ports
//   clk, rst          core clock, synchronous active-high reset
//   bus_req_i/gnt_o   request / grant (grant follows request, no stall)
//   bus_we_i          1 = write, 0 = read
//   bus_addr_i        byte address, word aligned
//   bus_wdata_i       write data
//   bus_rvalid_o      response valid, one cycle after grant
//   bus_rdata_o       read data (0 when no read response)
//   fast_irq_i        fast interrupt lines, rising-edge sensitive
//   ext_irq_i         external interrupt, level sensitive
//   irq_ack_i/id_i    core acknowledge and id of acknowledged interrupt
//   irq_o             interrupt vector to the core
//
// Register map (byte offsets)
//   0x00 MSIP[0]  0x04 MTIMECMP_LO  0x08 MTIMECMP_HI
//   0x0C MTIME_LO 0x10 MTIME_HI     0x14 FAST_PEND[15:0] (write-1-to-clear)
module rv32imf_irq_source #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req_i,
  output logic              bus_gnt_o,
  input  logic              bus_we_i,
  input  logic [ADDR_W-1:0] bus_addr_i,
  input  logic [31:0]       bus_wdata_i,
  output logic              bus_rvalid_o,
  output logic [31:0]       bus_rdata_o,
  input  logic [15:0]       fast_irq_i,
  input  logic              ext_irq_i,
  input  logic              irq_ack_i,
  input  logic [4:0]        irq_id_i,
  output logic [31:0]       irq_o
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef logic [ADDR_W-3:0] widx_t;
  localparam widx_t IDX_MSIP      = widx_t'(0);
  localparam widx_t IDX_MTCMP_LO  = widx_t'(1);
  localparam widx_t IDX_MTCMP_HI  = widx_t'(2);
  localparam widx_t IDX_MTIME_LO  = widx_t'(3);
  localparam widx_t IDX_MTIME_HI  = widx_t'(4);
  localparam widx_t IDX_FAST_PEND = widx_t'(5);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [63:0]       mtime_q, mtime_d;
  logic [63:0]       mtimecmp_q, mtimecmp_d;
  logic              msip_q, msip_d;
  logic              mtip_q;
  logic [15:0]       fast_pend_q, fast_pend_d;
  logic [15:0]       fast_prev_q;
  logic              ext_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q, rd_val;
  logic [15:0]       fast_sync, fast_rise, fast_clr;
  logic              ext_sync;
  logic              tick_wrap;
  logic              wr_en, rd_en;
  widx_t             widx;

  // Byte offset bits carry no information for word-only accesses.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus_addr_i[1:0];

`ifdef IRQ_SRC_SYNC_EN
  logic [15:0] fast_s1_q, fast_s2_q;
  logic        ext_s1_q, ext_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fast_s1_q <= '0;
      fast_s2_q <= '0;
      ext_s1_q  <= 1'b0;
      ext_s2_q  <= 1'b0;
    end else begin
      fast_s1_q <= fast_irq_i;
      fast_s2_q <= fast_s1_q;
      ext_s1_q  <= ext_irq_i;
      ext_s2_q  <= ext_s1_q;
    end
  end

  assign fast_sync = fast_s2_q;
  assign ext_sync  = ext_s2_q;
`else
  assign fast_sync = fast_irq_i;
  assign ext_sync  = ext_irq_i;
`endif

  assign bus_gnt_o = bus_req_i & ~rst;
  assign wr_en     = bus_req_i & bus_we_i;
  assign rd_en     = bus_req_i & ~bus_we_i;
  assign widx      = bus_addr_i[ADDR_W-1:2];

  // fast_prev_q is the previous sample of the (synced) line for edge detect.
  assign fast_rise = fast_sync & ~fast_prev_q;

  always_comb begin
    rd_val = '0;
    case (widx)
      IDX_MSIP:      rd_val = {31'd0, msip_q};
      IDX_MTCMP_LO:  rd_val = mtimecmp_q[31:0];
      IDX_MTCMP_HI:  rd_val = mtimecmp_q[63:32];
      IDX_MTIME_LO:  rd_val = mtime_q[31:0];
      IDX_MTIME_HI:  rd_val = mtime_q[63:32];
      IDX_FAST_PEND: rd_val = {16'd0, fast_pend_q};
      default:       rd_val = '0;
    endcase
  end

  always_comb begin
    tick_wrap  = (tick_q == TICK_LAST);
    tick_d     = tick_wrap ? '0 : tick_q + TICK_W'(1);
    mtime_d    = mtime_q + {63'd0, tick_wrap};
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    fast_clr   = '0;
    // Only fast ids (16..31) are cleared by acknowledge.
    if (irq_ack_i && irq_id_i[4]) fast_clr[irq_id_i[3:0]] = 1'b1;
    if (wr_en) begin
      case (widx)
        IDX_MSIP:      msip_d = bus_wdata_i[0];
        IDX_MTCMP_LO:  mtimecmp_d = {mtimecmp_q[63:32], bus_wdata_i};
        IDX_MTCMP_HI:  mtimecmp_d = {bus_wdata_i, mtimecmp_q[31:0]};
        // A write to either mtime half drops that cycle's increment.
        IDX_MTIME_LO:  mtime_d = {mtime_q[63:32], bus_wdata_i};
        IDX_MTIME_HI:  mtime_d = {bus_wdata_i, mtime_q[31:0]};
        IDX_FAST_PEND: fast_clr = fast_clr | bus_wdata_i[15:0];
        default: ;
      endcase
    end
    // Set wins over a simultaneous clear.
    fast_pend_d = (fast_pend_q & ~fast_clr) | fast_rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q      <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      mtip_q      <= 1'b0;
      fast_pend_q <= '0;
      fast_prev_q <= '0;
      ext_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      tick_q      <= tick_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      mtip_q      <= (mtime_q >= mtimecmp_q);
      fast_pend_q <= fast_pend_d;
      fast_prev_q <= fast_sync;
      ext_q       <= ext_sync;
      rvalid_q    <= bus_req_i;
      rdata_q     <= rd_en ? rd_val : 32'd0;
    end
  end

  assign bus_rvalid_o = rvalid_q;
  assign bus_rdata_o  = rdata_q;
  assign irq_o = {fast_pend_q, 4'b0, ext_q, 3'b0, mtip_q, 3'b0, msip_q, 3'b0};

endmodule

// File: tb/tb_rv32imf_irq_source.sv
module tb_rv32imf_irq_source;
  localparam int TD = 4;
`ifdef IRQ_SRC_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_req, bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [15:0] fast_irq;
  logic        ext_irq, irq_ack;
  logic [4:0]  irq_id;
  logic        bus_gnt_o, bus_rvalid_o;
  logic [31:0] bus_rdata_o, irq_o;

  rv32imf_irq_source #(.TICK_DIV(TD), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .bus_req_i(bus_req), .bus_gnt_o(bus_gnt_o), .bus_we_i(bus_we),
    .bus_addr_i(bus_addr), .bus_wdata_i(bus_wdata),
    .bus_rvalid_o(bus_rvalid_o), .bus_rdata_o(bus_rdata_o),
    .fast_irq_i(fast_irq), .ext_irq_i(ext_irq),
    .irq_ack_i(irq_ack), .irq_id_i(irq_id), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: architectural state of the unit.
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_mtip, m_ext, m_rvalid;
  logic [31:0] m_rdata;
  logic [15:0] m_pend;
  int          m_tick;
  logic [15:0] fh [4];   // fh[n] = fast input sampled n edges ago
  logic        eh [4];

  function automatic logic [31:0] m_reg(input int idx);
    case (idx)
      0: return {31'd0, m_msip};
      1: return m_cmp[31:0];
      2: return m_cmp[63:32];
      3: return m_mtime[31:0];
      4: return m_mtime[63:32];
      5: return {16'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_irq();
    return {m_pend, 4'b0, m_ext, 3'b0, m_mtip, 3'b0, m_msip, 3'b0};
  endfunction

  task automatic model_edge();
    int          idx;
    logic [63:0] nt;
    logic [15:0] clr, rise;
    logic        wr;
    if (rst) begin
      m_mtime = 64'd0; m_cmp = '1; m_msip = 0; m_mtip = 0; m_ext = 0;
      m_rvalid = 0; m_rdata = 0; m_pend = 0; m_tick = 0;
      for (int k = 0; k < 4; k++) begin fh[k] = 16'd0; eh[k] = 1'b0; end
      return;
    end
    for (int k = 3; k > 0; k--) begin fh[k] = fh[k-1]; eh[k] = eh[k-1]; end
    fh[0] = fast_irq; eh[0] = ext_irq;
    idx = int'(bus_addr[4:2]);
    wr  = bus_req && bus_we;
    m_rdata  = (bus_req && !bus_we) ? m_reg(idx) : 32'd0;
    m_rvalid = bus_req;
    m_mtip   = (m_mtime >= m_cmp);
    nt = m_mtime + ((m_tick == TD - 1) ? 64'd1 : 64'd0);
    m_tick = (m_tick + 1) % TD;
    clr = (irq_ack && irq_id >= 5'd16) ? (16'd1 << (irq_id - 5'd16)) : 16'd0;
    if (wr) begin
      case (idx)
        0: m_msip = bus_wdata[0];
        1: m_cmp[31:0]  = bus_wdata;
        2: m_cmp[63:32] = bus_wdata;
        3: nt = {m_mtime[63:32], bus_wdata};
        4: nt = {bus_wdata, m_mtime[31:0]};
        5: clr = clr | bus_wdata[15:0];
        default: ;
      endcase
    end
    m_mtime = nt;
    rise   = fh[SYNC_D] & ~fh[SYNC_D+1];
    m_pend = (m_pend & ~clr) | rise;
    m_ext  = eh[SYNC_D];
  endtask

  task automatic cyc();
    #1 check_eq("gnt", bus_gnt_o, bus_req & ~rst);
    @(posedge clk);
    model_edge();
    #1;
    check_eq("rvalid", bus_rvalid_o, m_rvalid);
    check_eq("rdata", bus_rdata_o, m_rdata);
    check_eq("irq", irq_o, m_irq());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus_req = 0; bus_we = 0; irq_ack = 0;
      cyc();
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    bus_req = 1; bus_we = 1; bus_addr = a; bus_wdata = d; irq_ack = 0;
    cyc();
    bus_req = 0; bus_we = 0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    bus_req = 1; bus_we = 0; bus_addr = a; irq_ack = 0;
    cyc();
    d = bus_rdata_o;
    check_eq("rd_rvalid", bus_rvalid_o, 1'b1);
    bus_req = 0;
  endtask

  initial begin
    logic [31:0] d;
    int n;
    rst = 1; bus_req = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0;
    fast_irq = 0; ext_irq = 0; irq_ack = 0; irq_id = 0;
    for (int k = 0; k < 4; k++) begin fh[k] = 16'd0; eh[k] = 1'b0; end
    @(posedge clk); #1;
    cyc(); cyc();
    rst = 0;
    check_eq("rst_irq", irq_o, 32'd0);
    check_eq("rst_rvalid", bus_rvalid_o, 1'b0);
    bus_rd(5'h00, d); check_eq("rst_msip", d, 32'd0);
    bus_rd(5'h04, d); check_eq("rst_cmp_lo", d, 32'hFFFF_FFFF);
    bus_rd(5'h08, d); check_eq("rst_cmp_hi", d, 32'hFFFF_FFFF);
    bus_rd(5'h10, d); check_eq("rst_mtime_hi", d, 32'd0);
    bus_rd(5'h14, d); check_eq("rst_pend", d, 32'd0);

    // Timer compare
    bus_wr(5'h0C, 32'd0); bus_wr(5'h10, 32'd0);
    bus_wr(5'h08, 32'd0); bus_wr(5'h04, 32'd5);
    n = 0;
    while (!irq_o[7] && n < 100) begin idle(1); n++; end
    check_eq("mtip_rise", irq_o[7], 1'b1);
    bus_rd(5'h0C, d); check_eq("mtime_at_rise", d, 32'd5);

    // 64-bit wrap
    bus_wr(5'h10, 32'hFFFF_FFFF); bus_wr(5'h0C, 32'hFFFF_FFFF);
    idle(TD);
    bus_rd(5'h0C, d); check_eq("wrap_lo", d, 32'd0);
    bus_rd(5'h10, d); check_eq("wrap_hi", d, 32'd0);

    // Fast pulse and acknowledge
    idle(3);
    fast_irq[2] = 1; cyc(); fast_irq[2] = 0; idle(SYNC_D);
    check_eq("fast2_set", irq_o[18], 1'b1);
    irq_ack = 1; irq_id = 5'd18; cyc(); irq_ack = 0;
    check_eq("fast2_ack", irq_o[18], 1'b0);

    // Set wins over coincident acknowledge, then W1C
    fast_irq[0] = 1; cyc(); fast_irq[0] = 0; idle(SYNC_D + 2);
    check_eq("fast0_pre", irq_o[16], 1'b1);
    fast_irq[0] = 1; idle(SYNC_D);
    irq_ack = 1; irq_id = 5'd16; cyc(); irq_ack = 0;
    check_eq("set_wins", irq_o[16], 1'b1);
    bus_wr(5'h14, 32'h1);
    check_eq("w1c", irq_o[16], 1'b0);
    fast_irq[0] = 0;

    // Acknowledge of a non-fast id leaves pendings alone
    fast_irq[5] = 1; cyc(); fast_irq[5] = 0; idle(SYNC_D);
    irq_ack = 1; irq_id = 5'd5; cyc(); irq_ack = 0;
    check_eq("ack_low_id", irq_o[21], 1'b1);

    // MSIP, unmapped access, external line
    bus_wr(5'h00, 32'h1); check_eq("msip_set", irq_o[3], 1'b1);
    bus_wr(5'h00, 32'h0); check_eq("msip_clr", irq_o[3], 1'b0);
    bus_wr(5'h18, 32'hFFFF_FFFF);
    bus_rd(5'h1C, d); check_eq("unmapped_rd", d, 32'd0);
    ext_irq = 1; idle(SYNC_D + 1);
    check_eq("ext_set", irq_o[11], 1'b1);
    ext_irq = 0; idle(SYNC_D + 1);
    check_eq("ext_clr", irq_o[11], 1'b0);

    // Reset during an outstanding read
    bus_req = 1; bus_we = 0; bus_addr = 5'h04; cyc();
    rst = 1; bus_req = 0; cyc(); rst = 0;
    check_eq("rst_mid_rvalid", bus_rvalid_o, 1'b0);
    check_eq("rst_mid_irq", irq_o, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      bus_req   = 1'($urandom_range(0, 1));
      bus_we    = 1'($urandom_range(0, 1));
      bus_addr  = 5'($urandom);
      bus_wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      fast_irq  = fast_irq ^ 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) ext_irq = ~ext_irq;
      irq_ack   = ($urandom_range(0, 3) == 0);
      irq_id    = 5'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
